ps2_rx: RTL and testbench



---
 rtl/ps2_rx_if.sv | 31 +++
 rtl/ps2_rx.sv | 180 ++++++++++++++++++
 tb/tb_ps2_rx.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_rx_if.sv
// ---------------------------------------------------------------------------
// ps2_rx_if : PS/2 pin pair plus receive-FIFO handshake for one ps2_rx channel
// Revision  : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface ps2_rx_if #(
  parameter int FIFO_BITS = 3
);
  logic                 ps2_clk;
  logic                 ps2_data;
  logic [7:0]           rx_data;
  logic                 rx_valid;
  logic                 rx_rd;
  logic [FIFO_BITS:0]   fifo_count;
  logic                 busy;
  logic                 frame_err;
  logic                 overflow;

  modport master (
    input  ps2_clk, ps2_data, rx_rd,
    output rx_data, rx_valid, fifo_count, busy, frame_err, overflow
  );

  modport slave (
    output ps2_clk, ps2_data, rx_rd,
    input  rx_data, rx_valid, fifo_count, busy, frame_err, overflow
  );
endinterface

`default_nettype wire

// File: rtl/ps2_rx.sv
// ---------------------------------------------------------------------------
// ps2_rx : synchronised, glitch-filtered PS/2 frame receiver with FWFT FIFO
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ps2_rx #(
  parameter int FILTER       = 4,
  parameter int TIMEOUT_BITS = 16,
  parameter int FIFO_BITS    = 3
) (
  input  wire logic   clk,
  input  wire logic   reset,
  ps2_rx_if.master    bus
);

  localparam int         DEPTH     = 1 << FIFO_BITS;
  localparam logic [3:0] FILT_LAST = 4'(FILTER - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  logic [1:0]              clk_sync_q;
  logic [1:0]              dat_sync_q;
  logic                    fclk_q;
  logic [3:0]              fcnt_q;
  logic                    fall_q;

  state_t                  state_q;
  logic [3:0]              bitcnt_q;
  logic [7:0]              shreg_q;
  logic                    par_q;
  logic [TIMEOUT_BITS-1:0] wdog_q;
  logic                    busy_q;
  logic                    frame_err_q;
  logic                    overflow_q;

  logic [7:0]              mem [DEPTH];
  logic [FIFO_BITS-1:0]    wptr_q;
  logic [FIFO_BITS-1:0]    rptr_q;
  logic [FIFO_BITS:0]      count_q;

  logic w_data;
  logic w_push;
  logic w_pop;
  logic w_full;
  logic w_wr;

  // Filtered clock only moves after FILTER consecutive disagreeing samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      fclk_q     <= 1'b1;
      fcnt_q     <= 4'd0;
      fall_q     <= 1'b0;
    end else begin
      clk_sync_q <= {clk_sync_q[0], bus.ps2_clk};
      dat_sync_q <= {dat_sync_q[0], bus.ps2_data};
      fall_q     <= 1'b0;
      if (clk_sync_q[1] != fclk_q) begin
        if (fcnt_q == FILT_LAST) begin
          fclk_q <= clk_sync_q[1];
          fcnt_q <= 4'd0;
          fall_q <= ~clk_sync_q[1];
        end else begin
          fcnt_q <= fcnt_q + 4'd1;
        end
      end else begin
        fcnt_q <= 4'd0;
      end
    end
  end

  assign w_data = dat_sync_q[1];
  assign w_push = (state_q == RECV) && fall_q && (bitcnt_q == 4'd10) && !par_q && w_data;
  assign w_pop  = bus.rx_rd && (count_q != '0);
  assign w_full = count_q[FIFO_BITS];
  assign w_wr   = w_push && (!w_full || w_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      bitcnt_q    <= 4'd0;
      shreg_q     <= 8'h00;
      par_q       <= 1'b0;
      wdog_q      <= '0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          wdog_q <= '0;
          if (fall_q) begin
            if (!w_data) begin
              state_q  <= RECV;
              busy_q   <= 1'b1;
              bitcnt_q <= 4'd1;
              par_q    <= 1'b1;
            end else begin
              frame_err_q <= 1'b1;
            end
          end
        end
        RECV: begin
          // A fall in the saturation cycle still counts as a valid bit.
          if (fall_q) begin
            wdog_q <= '0;
            if (bitcnt_q <= 4'd8) begin
              shreg_q[3'(bitcnt_q - 4'd1)] <= w_data;
              par_q    <= par_q ^ w_data;
              bitcnt_q <= bitcnt_q + 4'd1;
            end else if (bitcnt_q == 4'd9) begin
              par_q    <= par_q ^ w_data;
              bitcnt_q <= bitcnt_q + 4'd1;
            end else begin
              if (par_q || !w_data) begin
                frame_err_q <= 1'b1;
              end
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else if (wdog_q == '1) begin
            frame_err_q <= 1'b1;
            state_q     <= IDLE;
            busy_q      <= 1'b0;
          end else begin
            wdog_q <= wdog_q + TIMEOUT_BITS'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) begin
      mem[wptr_q] <= shreg_q;
    end
  end

  // A pop in the same cycle frees the slot, so a push into a full FIFO succeeds.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= w_push && w_full && !w_pop;
      if (w_wr) begin
        wptr_q <= wptr_q + FIFO_BITS'(1);
      end
      if (w_pop) begin
        rptr_q <= rptr_q + FIFO_BITS'(1);
      end
      case ({w_wr, w_pop})
        2'b10:   count_q <= count_q + (FIFO_BITS+1)'(1);
        2'b01:   count_q <= count_q - (FIFO_BITS+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign bus.rx_valid   = (count_q != '0);
  assign bus.rx_data    = (count_q != '0) ? mem[rptr_q] : 8'h00;
  assign bus.fifo_count = count_q;
  assign bus.busy       = busy_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.overflow   = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_ps2_rx.sv
// ---------------------------------------------------------------------------
// tb_ps2_rx : directed, table-driven self-checking bench for ps2_rx
// Revision  : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ps2_rx;

  localparam int FILTER = 4;
  localparam int TOB    = 8;
  localparam int FB     = 3;
  localparam int HALF   = 40;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ps2_rx_if #(.FIFO_BITS(FB)) bus ();

  ps2_rx #(
    .FILTER       (FILTER),
    .TIMEOUT_BITS (TOB),
    .FIFO_BITS    (FB)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp   = 0;
  int n_bad   = 0;
  int err_cnt = 0;
  int ovf_cnt = 0;
  int lat     = 99;

  typedef struct {
    logic [7:0] b;
    bit         bad_par;
    bit         stop;
    int         exp_err;
    int         exp_cnt;
  } vec_t;

  vec_t tbl [8];

  always @(negedge clk) begin
    if (bus.frame_err === 1'b1) err_cnt++;
    if (bus.overflow === 1'b1) ovf_cnt++;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input bit d, input bit glitch);
    @(negedge clk);
    bus.ps2_data = d;
    if (glitch) begin
      wait_clks(HALF/2);
      bus.ps2_clk = 1'b0;
      wait_clks(2);
      bus.ps2_clk = 1'b1;
      wait_clks(HALF/2 - 3);
    end else begin
      wait_clks(HALF - 1);
    end
    bus.ps2_clk = 1'b0;
    wait_clks(HALF);
    bus.ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit stop,
                            input bit pop_at_push, input int glitch_bit);
    logic [10:0] bits;
    logic [FB:0] cnt0;
    bits = {stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 10; i++) send_bit(bits[i], (i == glitch_bit));
    @(negedge clk);
    bus.ps2_data = bits[10];
    wait_clks(HALF - 1);
    cnt0 = bus.fifo_count;
    bus.ps2_clk = 1'b0;
    lat = 99;
    for (int j = 1; j <= HALF; j++) begin
      @(negedge clk);
      if (pop_at_push && j == 6) bus.rx_rd = 1'b1;
      if (j == 7) bus.rx_rd = 1'b0;
      if (lat == 99 && cnt0 == 0 && bus.rx_valid) lat = j;
    end
    bus.ps2_clk = 1'b1;
    wait_clks(HALF);
  endtask

  task automatic pop_exp(input string nm, input logic [7:0] e);
    check({nm, "_valid"}, bus.rx_valid, 1);
    check({nm, "_data"}, bus.rx_data, e);
    bus.rx_rd = 1'b1;
    @(negedge clk);
    bus.rx_rd = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (bus.rx_valid && g < 20) begin
      bus.rx_rd = 1'b1;
      @(negedge clk);
      bus.rx_rd = 1'b0;
      g++;
    end
    @(negedge clk);
  endtask

  initial begin
    int e0, o0, t;

    tbl[0] = '{8'h1C, 1'b0, 1'b1, 0, 1};
    tbl[1] = '{8'hF0, 1'b0, 1'b1, 0, 1};
    tbl[2] = '{8'hF0, 1'b1, 1'b1, 1, 0};
    tbl[3] = '{8'h00, 1'b0, 1'b1, 0, 1};
    tbl[4] = '{8'hFF, 1'b0, 1'b1, 0, 1};
    tbl[5] = '{8'hA5, 1'b0, 1'b0, 1, 0};
    tbl[6] = '{8'h5A, 1'b0, 1'b1, 0, 1};
    tbl[7] = '{8'h80, 1'b1, 1'b1, 1, 0};

    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    bus.rx_rd    = 1'b0;
    reset        = 1'b1;
    wait_clks(3);
    check("rst_valid", bus.rx_valid, 0);
    check("rst_count", bus.fifo_count, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_err", bus.frame_err, 0);
    check("rst_ovf", bus.overflow, 0);
    check("rst_data", bus.rx_data, 0);
    reset = 1'b0;
    wait_clks(5);

    // Basic frame with latency bound
    e0 = err_cnt; o0 = ovf_cnt;
    send_frame(8'h1C, 0, 1, 0, -1);
    check("lat_le_bound", (lat <= FILTER + 4), 1);
    check("b1_data", bus.rx_data, 8'h1C);
    check("b1_count", bus.fifo_count, 1);
    check("b1_err", err_cnt - e0, 0);
    check("b1_ovf", ovf_cnt - o0, 0);
    bus.rx_rd = 1'b1; @(negedge clk); bus.rx_rd = 1'b0;
    check("b1_pop_valid", bus.rx_valid, 0);
    check("b1_pop_count", bus.fifo_count, 0);
    bus.rx_rd = 1'b1; @(negedge clk); bus.rx_rd = 1'b0;
    check("empty_rd_count", bus.fifo_count, 0);

    // Table of single frames, FIFO drained between vectors
    for (int i = 0; i < 8; i++) begin
      e0 = err_cnt;
      send_frame(tbl[i].b, tbl[i].bad_par, tbl[i].stop, 0, -1);
      check($sformatf("tbl%0d_err", i), err_cnt - e0, tbl[i].exp_err);
      check($sformatf("tbl%0d_count", i), bus.fifo_count, tbl[i].exp_cnt);
      if (tbl[i].exp_cnt == 1) check($sformatf("tbl%0d_data", i), bus.rx_data, tbl[i].b);
      drain();
    end

    // Start bit of 1 in IDLE
    e0 = err_cnt;
    send_bit(1'b1, 1'b0);
    wait_clks(HALF);
    check("badstart_err", err_cnt - e0, 1);
    check("badstart_busy", bus.busy, 0);

    // Good F0 then bad-parity F0 without reading
    e0 = err_cnt;
    send_frame(8'hF0, 0, 1, 0, -1);
    send_frame(8'hF0, 1, 1, 0, -1);
    check("f0_err", err_cnt - e0, 1);
    check("f0_count", bus.fifo_count, 1);
    check("f0_data", bus.rx_data, 8'hF0);
    drain();

    // Overflow: nine frames, no reads
    o0 = ovf_cnt;
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 0, 1, 0, -1);
    check("ovf_count", bus.fifo_count, 8);
    check("ovf_pulses", ovf_cnt - o0, 1);
    for (int i = 1; i <= 8; i++) pop_exp($sformatf("ovf_rd%0d", i), 8'(i));
    check("ovf_empty", bus.rx_valid, 0);

    // Full FIFO with pop coinciding with the ninth push
    o0 = ovf_cnt;
    for (int i = 1; i <= 8; i++) send_frame(8'(i), 0, 1, 0, -1);
    send_frame(8'h09, 0, 1, 1, -1);
    check("pp_count", bus.fifo_count, 8);
    check("pp_ovf", ovf_cnt - o0, 0);
    for (int i = 2; i <= 9; i++) pop_exp($sformatf("pp_rd%0d", i), 8'(i));

    // Watchdog timeout after five bits
    e0 = err_cnt;
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
    check("to_busy_mid", bus.busy, 1);
    @(negedge clk);
    bus.ps2_data = 1'b0;
    wait_clks(HALF - 1);
    bus.ps2_clk = 1'b0;
    t = 0;
    while (bus.frame_err !== 1'b1 && t < 400) begin
      @(negedge clk);
      t++;
      if (t == HALF) bus.ps2_clk = 1'b1;
    end
    check("to_time_in_window", (t >= 256 && t <= 256 + FILTER + 4), 1);
    wait_clks(2);
    check("to_busy_after", bus.busy, 0);
    check("to_err", err_cnt - e0, 1);
    check("to_count", bus.fifo_count, 0);
    send_frame(8'h5A, 0, 1, 0, -1);
    check("to_next_data", bus.rx_data, 8'h5A);
    drain();

    // Glitches in IDLE and mid-frame
    e0 = err_cnt;
    @(negedge clk);
    bus.ps2_clk = 1'b0;
    wait_clks(2);
    bus.ps2_clk = 1'b1;
    wait_clks(20);
    check("gl_idle_busy", bus.busy, 0);
    send_frame(8'h3C, 0, 1, 0, 4);
    check("gl_err", err_cnt - e0, 0);
    check("gl_count", bus.fifo_count, 1);
    check("gl_data", bus.rx_data, 8'h3C);
    drain();

    // Reset during bit 6 with three bytes buffered
    send_frame(8'h11, 0, 1, 0, -1);
    send_frame(8'h22, 0, 1, 0, -1);
    send_frame(8'h33, 0, 1, 0, -1);
    check("rs_pre_count", bus.fifo_count, 3);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
    @(negedge clk);
    bus.ps2_data = 1'b0;
    wait_clks(10);
    reset = 1'b1;
    wait_clks(2);
    check("rs_valid", bus.rx_valid, 0);
    check("rs_count", bus.fifo_count, 0);
    check("rs_busy", bus.busy, 0);
    check("rs_data", bus.rx_data, 0);
    reset = 1'b0;
    wait_clks(HALF);
    e0 = err_cnt;
    send_frame(8'hAA, 0, 1, 0, -1);
    check("rs_next_count", bus.fifo_count, 1);
    check("rs_next_data", bus.rx_data, 8'hAA);
    check("rs_next_err", err_cnt - e0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
